arb_mux_nto1: RTL and testbench
===============================

# arb_mux_nto1

Parametrised N-channel, W-bit arbitrated selector with one registered output stage. Replaces the fixed 2:1 mux trees where several producers share a single consumer. Each cycle it selects one requesting channel, using either fixed priority or round-robin, and registers that channel's data towards a valid/ready consumer. Full throughput is one transfer per cycle; latency is one cycle.

## Interface
Parameters:
- NCH, 4, number of input channels (≥2; need not be a power of 2)
- W, 8, data width per channel
- IDXW, 2, channel-index width; must equal ceil(log2(NCH))

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin
- in_valid  input  NCH  per-channel request
- in_data  input  NCH*W  channel k occupies bits [k*W +: W]
- in_ready  output  NCH  per-channel accept; one-hot or zero
- out_valid  output  1  output register holds a word
- out_data  output  W  registered data
- out_ch  output  IDXW  source channel of out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Internal state:
  - out_valid, out_data, out_ch
  - round-robin pointer ptr (IDXW bits, range 0..NCH-1)
- load = ~out_valid | out_ready: the output slot is free this cycle.
- Grant g (combinational):
  - Computed only when load = 1 and in_valid != 0.
  - mode 0: g is the lowest index k with in_valid[k] = 1.
  - mode 1: g is the first k with in_valid[k] = 1, searching ptr, ptr+1, …, NCH-1, then 0, …, ptr-1.
- in_ready[g] = 1 only for the granted channel. All other in_ready bits are 0.
- All in_ready bits are 0 when load = 0, when in_valid = 0, or while rst = 1.
- in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- On a clock edge with load = 1:
  - If a grant exists: out_valid <= 1, out_data <= in_data[g], out_ch <= g.
  - If no channel requests: out_valid <= 0; out_data and out_ch hold their previous values.
- On a clock edge with load = 0: all output registers hold.
- ptr update:
  - Changes only on a grant in mode 1: ptr <= (g == NCH-1) ? 0 : g+1.
  - Unchanged in mode 0.
  - Retained across mode changes.
- Mode changes take effect on the arbitration in the same cycle; no state flush.
- Channel data is never dropped or duplicated. A channel's word transfers exactly when in_valid[k] & in_ready[k].

## Timing
- Reset values (after the rst edge): out_valid = 0, out_data = 0, out_ch = 0, ptr = 0. in_ready = 0 while rst is high.
- Reset mid-transfer: a pending out_valid word is discarded. No in_ready is asserted in the rst cycle, so no input is consumed.
- Latency: input accepted at edge n → out_valid = 1 with that data after edge n.
- Throughput: with out_ready held at 1, one transfer per cycle and no bubbles.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data and out_ch are stable and in_ready = 0.
- Simultaneous drain and refill (out_valid = 1, out_ready = 1, a channel requesting): the word is consumed and a new one loaded in the same cycle.
- Wrap-around: in mode 1 with NCH not a power of 2, ptr goes from NCH-1 to 0. ptr never reaches NCH.

## Test plan
- Reset:
  - Stimulus: NCH=4, W=8; all in_valid = 1; rst high for 2 cycles.
  - Response: in_ready = 0000, out_valid = 0, out_data = 0x00, out_ch = 0 throughout. First grant goes to ch0 in the cycle after rst falls.
- Fixed priority:
  - Stimulus: mode = 0, in_valid = 1010, ch1 = 0x11, ch3 = 0x33, out_ready = 1.
  - Response: in_ready = 0010 every cycle; out_ch = 1 and out_data = 0x11 one cycle later. Ch3 is granted only after in_valid[1] drops.
- Round-robin fairness:
  - Stimulus: mode = 1, in_valid = 1111, ch k data = 0xA0+k, out_ready = 1.
  - Response: out_ch sequence 0, 1, 2, 3, 0 with out_data 0xA0, 0xA1, 0xA2, 0xA3, 0xA0.
- Round-robin skip and wrap:
  - Stimulus: mode = 1, ptr = 2 (ch1 was just granted), in_valid = 0001.
  - Response: ch0 granted; ptr becomes 1.
  - Variant with NCH = 3: a grant of ch2 sets ptr to 0.
- Backpressure:
  - Stimulus: out_valid = 1 with out_data = 0x55; out_ready = 0 for 3 cycles with all channels valid.
  - Response: in_ready = 0000 and out_data stays 0x55 for all 3 cycles.
  - When out_ready rises, 0x55 is consumed and the next granted word appears on the following edge with no gap.
- Reset mid-stream:
  - Stimulus: during the round-robin scenario, assert rst for 1 cycle.
  - Response: out_valid = 0 and ptr = 0; after release the next grant is ch0.

Source files
------------

// File: rtl/arb_mux_nto1.sv
// rtl/arb_mux_nto1.sv - N-channel arbitrated selector with registered valid/ready output
module arb_mux_nto1 #(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int IDXW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*W-1:0]  in_data,
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [IDXW-1:0]   out_ch,
    input  logic              out_ready
);

    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] gsel;
    logic [IDXW-1:0] ptr_nxt;
    logic [IDXW-1:0] cand;
    logic [IDXW:0]   sum;
    logic            found;
    logic            load;
    logic            grant;
    logic [W-1:0]    chan [NCH];
    logic [W-1:0]    gdata;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            chan[k] = in_data[k*W +: W];
        end
    end

    assign load = ~out_valid | out_ready;

    // Walk the channels starting at ptr (round-robin) or 0 (fixed), wrapping at NCH.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = {1'b0, (mode ? ptr : {IDXW{1'b0}})} + (IDXW+1)'(i);
            if (sum >= (IDXW+1)'(NCH)) begin
                sum = sum - (IDXW+1)'(NCH);
            end
            cand = sum[IDXW-1:0];
            if (!found && in_valid[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
    end

    assign gdata   = chan[gsel];
    assign grant   = load & found & ~rst;
    assign ptr_nxt = (gsel == IDXW'(NCH-1)) ? '0 : gsel + 1'b1;

    always_comb begin
        in_ready = '0;
        if (grant) begin
            in_ready[gsel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_ch    <= gsel;
                if (mode) begin
                    ptr <= ptr_nxt;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_nto1.sv
// tb/tb_arb_mux_nto1.sv - table, directed and randomized checks of arb_mux_nto1 (NCH=4 and NCH=3)
module tb_arb_mux_nto1;

    logic        clk = 1'b0;
    logic        rst, mode, out_ready;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic [2:0]  b_in_ready;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_mux_nto1 #(.NCH(4), .W(8), .IDXW(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ch(out_ch), .out_ready(out_ready)
    );

    arb_mux_nto1 #(.NCH(3), .W(8), .IDXW(2)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid[2:0]), .in_data(in_data[23:0]),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_ready(out_ready)
    );

    // Reference state per instance: [0] NCH=4, [1] NCH=3
    bit       m_v  [2] = '{0, 0};
    bit [7:0] m_d  [2] = '{0, 0};
    int       m_ch [2] = '{0, 0};
    int       m_p  [2] = '{0, 0};

    typedef struct {
        bit        r;
        bit        md;
        bit [3:0]  v;
        bit [31:0] d;
        bit        o;
        bit [3:0]  e_rdy;
        bit        e_ov;
        bit [7:0]  e_od;
        bit [1:0]  e_och;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle: drive, check in_ready before the edge, update model, check outputs at negedge.
    task automatic step(input bit r, input bit md, input bit [3:0] v, input bit [31:0] d,
                        input bit o, output logic [3:0] rdy_seen);
        int       g [2];
        bit [3:0] er [2];
        int       n;
        int       k;
        rst = r; mode = md; in_valid = v; in_data = d; out_ready = o;
        #1;
        for (int inst = 0; inst < 2; inst++) begin
            n = (inst == 0) ? 4 : 3;
            g[inst] = -1;
            er[inst] = '0;
            if (!r && (!m_v[inst] || o)) begin
                for (int j = 0; j < n; j++) begin
                    k = md ? (m_p[inst] + j) % n : j;
                    if (g[inst] < 0 && v[k]) g[inst] = k;
                end
            end
            if (g[inst] >= 0) er[inst][g[inst]] = 1'b1;
        end
        rdy_seen = in_ready;
        check("in_ready", {28'd0, in_ready}, {28'd0, er[0]});
        check("b_in_ready", {29'd0, b_in_ready}, {28'd0, er[1]});
        @(posedge clk);
        for (int inst = 0; inst < 2; inst++) begin
            n = (inst == 0) ? 4 : 3;
            if (r) begin
                m_v[inst] = 0; m_d[inst] = 0; m_ch[inst] = 0; m_p[inst] = 0;
            end else if (!m_v[inst] || o) begin
                if (g[inst] >= 0) begin
                    m_v[inst] = 1;
                    m_d[inst] = d[g[inst]*8 +: 8];
                    m_ch[inst] = g[inst];
                    if (md) m_p[inst] = (g[inst] + 1) % n;
                end else begin
                    m_v[inst] = 0;
                end
            end
        end
        @(negedge clk);
        check("out_valid", {31'd0, out_valid}, {31'd0, m_v[0]});
        check("out_data", {24'd0, out_data}, {24'd0, m_d[0]});
        check("out_ch", {30'd0, out_ch}, m_ch[0]);
        check("b_out_valid", {31'd0, b_out_valid}, {31'd0, m_v[1]});
        check("b_out_data", {24'd0, b_out_data}, {24'd0, m_d[1]});
        check("b_out_ch", {30'd0, b_out_ch}, m_ch[1]);
    endtask

    initial begin
        vec_t        tbl [24];
        logic [3:0]  rdy;
        bit [31:0]   rr = 32'hA3A2A1A0;
        bit [31:0]   fp = 32'h3300_1100;

        tbl[0]  = '{1, 0, 4'b1111, 32'h0,  1, 4'b0000, 0, 8'h00, 0};
        tbl[1]  = '{1, 0, 4'b1111, 32'h0,  1, 4'b0000, 0, 8'h00, 0};
        tbl[2]  = '{0, 0, 4'b1111, rr,     1, 4'b0001, 1, 8'hA0, 0};
        tbl[3]  = '{0, 0, 4'b1010, fp,     1, 4'b0010, 1, 8'h11, 1};
        tbl[4]  = '{0, 0, 4'b1010, fp,     1, 4'b0010, 1, 8'h11, 1};
        tbl[5]  = '{0, 0, 4'b1000, fp,     1, 4'b1000, 1, 8'h33, 3};
        tbl[6]  = '{0, 0, 4'b0000, fp,     1, 4'b0000, 0, 8'h33, 3};
        tbl[7]  = '{0, 1, 4'b1111, rr,     1, 4'b0001, 1, 8'hA0, 0};
        tbl[8]  = '{0, 1, 4'b1111, rr,     1, 4'b0010, 1, 8'hA1, 1};
        tbl[9]  = '{0, 1, 4'b1111, rr,     1, 4'b0100, 1, 8'hA2, 2};
        tbl[10] = '{0, 1, 4'b1111, rr,     1, 4'b1000, 1, 8'hA3, 3};
        tbl[11] = '{0, 1, 4'b1111, rr,     1, 4'b0001, 1, 8'hA0, 0};
        tbl[12] = '{0, 1, 4'b1111, rr,     1, 4'b0010, 1, 8'hA1, 1};
        tbl[13] = '{0, 1, 4'b0001, rr,     1, 4'b0001, 1, 8'hA0, 0};
        tbl[14] = '{0, 1, 4'b1111, rr,     1, 4'b0010, 1, 8'hA1, 1};
        tbl[15] = '{1, 1, 4'b1111, rr,     1, 4'b0000, 0, 8'h00, 0};
        tbl[16] = '{0, 1, 4'b1111, rr,     1, 4'b0001, 1, 8'hA0, 0};
        tbl[17] = '{0, 0, 4'b0100, 32'h0055_0000, 1, 4'b0100, 1, 8'h55, 2};
        tbl[18] = '{0, 0, 4'b1111, rr,     0, 4'b0000, 1, 8'h55, 2};
        tbl[19] = '{0, 0, 4'b1111, rr,     0, 4'b0000, 1, 8'h55, 2};
        tbl[20] = '{0, 0, 4'b1111, rr,     0, 4'b0000, 1, 8'h55, 2};
        tbl[21] = '{0, 0, 4'b1111, rr,     1, 4'b0001, 1, 8'hA0, 0};
        tbl[22] = '{0, 0, 4'b0000, rr,     1, 4'b0000, 0, 8'hA0, 0};
        tbl[23] = '{0, 0, 4'b0000, rr,     0, 4'b0000, 0, 8'hA0, 0};

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].r, tbl[i].md, tbl[i].v, tbl[i].d, tbl[i].o, rdy);
            check($sformatf("vec%0d_rdy", i), {28'd0, rdy}, {28'd0, tbl[i].e_rdy});
            check($sformatf("vec%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            check($sformatf("vec%0d_od", i), {24'd0, out_data}, {24'd0, tbl[i].e_od});
            check($sformatf("vec%0d_och", i), {30'd0, out_ch}, {30'd0, tbl[i].e_och});
        end

        // NCH=3 wrap: granting ch2 must send ptr to 0, so ch0 wins next
        step(1, 1, 4'b0000, 32'h0, 1, rdy);
        step(0, 1, 4'b0100, 32'h00C2C1C0, 1, rdy);
        check("wrap3_ch2", {30'd0, b_out_ch}, 32'd2);
        check("wrap3_d2", {24'd0, b_out_data}, 32'hC2);
        step(0, 1, 4'b0111, 32'h00C2C1C0, 1, rdy);
        check("wrap3_ch0", {30'd0, b_out_ch}, 32'd0);
        check("wrap3_d0", {24'd0, b_out_data}, 32'hC0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 4'($urandom),
                 $urandom, ($urandom_range(0, 3) != 0), rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
